comp_mac_pipe: RTL and testbench
================================

// Module: comp_mac_pipe
// PURPOSE
//  Parametrised successor of the complex-multiplier core: pipelined signed complex
//  multiply / conjugate-multiply / multiply-accumulate on a valid/ready stream.
//  Sits between the memory fetch controller (op side) and the result writer (res side)
//  inside comp_mult_top; one complex result per cycle at full throughput.
// PARAMETERS
//  DWIDTH     8   operand element width (signed two's complement)
//  ACC_GUARD  4   accumulator guard bits; max MAC length = 2**ACC_GUARD
//  CNT_W      16  width of res_cnt status counter
//  RW (local) = 2*DWIDTH+1+ACC_GUARD, result element width
// PORTS
//  clk          in   1            system clock, rising edge
//  rst_n        in   1            hw reset, asynchronous, active low
//  sw_rst       in   1            sw reset, synchronous, active high
//  cfg_mode     in   2            0 MUL, 1 CMUL (a*conj b), 2 MAC, 3 reserved (=MUL)
//  cfg_acc_len  in   ACC_GUARD+1  MAC group length; 0 treated as 1
//  op_val       in   1            operand valid
//  op_rdy       out  1            operand ready
//  op_data      in   4*DWIDTH     {x1,x2,y1,y2}; a = x1 + j*y1, b = x2 + j*y2
//  res_val      out  1            result valid
//  res_rdy      in   1            result ready
//  res_data     out  2*RW         {xr,yr}, signed
//  busy         out  1            pipeline or accumulator holds state
//  res_cnt      out  CNT_W        results handed off since reset, wraps
// BEHAVIOUR
//  Reset (rst_n=0 async, or sw_rst=1 at edge): s1_val, res_val, busy, res_cnt, acc,
//   grp_cnt, res_data all 0; shadow cfg = MUL, len 1. sw_rst overrides all traffic.
//  Config: cfg_mode/cfg_acc_len copied to shadow regs every cycle busy==0; ignored
//   while busy==1. busy = s1_val | res_val | (grp_cnt!=0).
//  Flow: adv = !res_val | res_rdy; op_rdy = adv (combinational). Op accepted on
//   op_val&op_rdy; result handed off on res_val&res_rdy. Global stall when adv=0.
//  Stage 1 (on adv): s1_val <= op accepted; four signed products x1x2, y1y2, x1y2, y1x2
//   (2*DWIDTH each) registered.
//  Combine: MUL re=x1x2-y1y2, im=x1y2+y1x2; CMUL/MAC-using-MUL form: CMUL re=x1x2+y1y2,
//   im=y1x2-x1y2; MAC uses MUL form. Each term 2*DWIDTH+1 bits, sign-extended to RW.
//  Stage 2 (on adv):
//   - s1_val=0: res_val <= 0.
//   - MUL/CMUL: res_data <= term, res_val <= 1.
//   - MAC: sum = (grp_cnt==0 ? 0 : acc) + term. If grp_cnt==len-1: res_data <= sum,
//     res_val <= 1, grp_cnt <= 0; else acc <= sum, grp_cnt++, res_val <= 0.
//  Latency: op accepted at edge k -> res_val high after edge k+1 (MUL/CMUL, no stall);
//   MAC emits after edge (last op)+1. Throughput 1 op/cycle while res_rdy=1.
//  res_data/res_val stable while res_val=1 & res_rdy=0; no op accepted during stall.
//  res_cnt increments on each res handshake; wraps 2**CNT_W-1 -> 0.
//  No overflow possible: |term| <= 2**(2*DWIDTH) and <= 2**ACC_GUARD terms fit RW.
//  Simultaneous handshake on both sides same cycle: allowed, no bubble.
//  Reset mid-MAC: partial group discarded; next op starts a new group.
//  res_data holds last value after handoff (not cleared).
// TESTING  (DWIDTH=8, ACC_GUARD=4)
//  MUL a=3+j4, b=5-j2 -> res {23,14}; res_val 2 edges after op handshake.
//  CMUL same operands -> res {7,26}.
//  MAC len 4, four ops a=b=-128-j128 -> one result {0,131072}; no res_val before 4th op
//   reaches stage 2; len 16 same ops -> {0,524288} with no wrap.
//  Back-pressure: MUL stream of 6 ops, res_rdy=0 cycles 3..7 -> op_rdy low same cycles,
//   res_data stable, all 6 results in order, res_cnt=6.
//  sw_rst after 2 of 4 MAC ops -> res_val 0, busy 0; next 4 ops give fresh-group sum only.
//  cfg_mode MUL->CMUL while busy=1 -> in-flight and queued ops remain MUL until busy=0.

Source files
------------

// File: rtl/comp_mac_pipe.sv
// comp_mac_pipe: two-stage signed complex multiply / conjugate multiply /
// multiply-accumulate on a valid/ready stream. One result per cycle at full rate.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low hw reset
//   sw_rst            sync active-high sw reset, overrides all traffic
//   cfg_mode          0 MUL, 1 CMUL (a*conj b), 2 MAC, 3 treated as MUL
//   cfg_acc_len       MAC group length, 0 treated as 1
//   op_val/op_rdy     operand stream, op_data = {x1,x2,y1,y2}
//   res_val/res_rdy   result stream, res_data = {xr,yr}
//   busy              pipeline or accumulator holds state
//   res_cnt           wrapping count of result handshakes
module comp_mac_pipe #(
    parameter int DWIDTH    = 8,
    parameter int ACC_GUARD = 4,
    parameter int CNT_W     = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    sw_rst,
    input  logic [1:0]                              cfg_mode,
    input  logic [ACC_GUARD:0]                      cfg_acc_len,
    input  logic                                    op_val,
    output logic                                    op_rdy,
    input  logic [4*DWIDTH-1:0]                     op_data,
    output logic                                    res_val,
    input  logic                                    res_rdy,
    output logic [2*(2*DWIDTH+1+ACC_GUARD)-1:0]     res_data,
    output logic                                    busy,
    output logic [CNT_W-1:0]                        res_cnt
);
    localparam int RW = 2*DWIDTH + 1 + ACC_GUARD;
    localparam int PW = 2*DWIDTH;
    localparam int TW = PW + 1;
    localparam int LW = ACC_GUARD + 1;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'd0,
        MODE_CMUL = 2'd1,
        MODE_MAC  = 2'd2,
        MODE_RSV  = 2'd3
    } mode_t;

    logic signed [DWIDTH-1:0] x1, x2, y1, y2;
    assign x1 = op_data[4*DWIDTH-1:3*DWIDTH];
    assign x2 = op_data[3*DWIDTH-1:2*DWIDTH];
    assign y1 = op_data[2*DWIDTH-1:DWIDTH];
    assign y2 = op_data[DWIDTH-1:0];

    logic                 s1_val_q, s1_val_d;
    logic signed [PW-1:0] pxx_q, pxx_d, pyy_q, pyy_d, pxy_q, pxy_d, pyx_q, pyx_d;
    logic                 res_val_q, res_val_d;
    logic [2*RW-1:0]      res_data_q, res_data_d;
    logic signed [RW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [LW-1:0]        grp_cnt_q, grp_cnt_d, len_q, len_d;
    mode_t                mode_q, mode_d;
    logic [CNT_W-1:0]     res_cnt_q, res_cnt_d;

    logic                 adv, grp_last;
    logic signed [TW-1:0] exx, eyy, exy, eyx, re_t, im_t;
    logic signed [RW-1:0] re_x, im_x, sum_re, sum_im;

    assign adv  = !res_val_q || res_rdy;
    assign busy = s1_val_q || res_val_q || (grp_cnt_q != '0);

    // Products are sign-extended by one bit so the add/sub cannot overflow.
    assign exx = {pxx_q[PW-1], pxx_q};
    assign eyy = {pyy_q[PW-1], pyy_q};
    assign exy = {pxy_q[PW-1], pxy_q};
    assign eyx = {pyx_q[PW-1], pyx_q};

    always_comb begin
        re_t = exx - eyy;
        im_t = exy + eyx;
        if (mode_q == MODE_CMUL) begin
            re_t = exx + eyy;
            im_t = eyx - exy;
        end
        re_x = {{(RW-TW){re_t[TW-1]}}, re_t};
        im_x = {{(RW-TW){im_t[TW-1]}}, im_t};
        // First term of a group ignores whatever the accumulator still holds.
        sum_re = ((grp_cnt_q == '0) ? '0 : acc_re_q) + re_x;
        sum_im = ((grp_cnt_q == '0) ? '0 : acc_im_q) + im_x;
        grp_last = (grp_cnt_q == len_q - LW'(1));
    end

    always_comb begin
        s1_val_d   = s1_val_q;
        pxx_d      = pxx_q;
        pyy_d      = pyy_q;
        pxy_d      = pxy_q;
        pyx_d      = pyx_q;
        res_val_d  = res_val_q;
        res_data_d = res_data_q;
        acc_re_d   = acc_re_q;
        acc_im_d   = acc_im_q;
        grp_cnt_d  = grp_cnt_q;
        len_d      = len_q;
        mode_d     = mode_q;
        res_cnt_d  = res_cnt_q;

        // Shadow config only follows the inputs while nothing is in flight,
        // so every op in a burst sees one consistent mode.
        if (!busy) begin
            mode_d = (cfg_mode == MODE_RSV) ? MODE_MUL : mode_t'(cfg_mode);
            len_d  = (cfg_acc_len == '0) ? LW'(1) : cfg_acc_len;
        end

        if (adv) begin
            s1_val_d = op_val;
            pxx_d    = PW'(x1) * PW'(x2);
            pyy_d    = PW'(y1) * PW'(y2);
            pxy_d    = PW'(x1) * PW'(y2);
            pyx_d    = PW'(y1) * PW'(x2);

            if (!s1_val_q) begin
                res_val_d = 1'b0;
            end else if (mode_q != MODE_MAC) begin
                res_data_d = {re_x, im_x};
                res_val_d  = 1'b1;
            end else if (grp_last) begin
                res_data_d = {sum_re, sum_im};
                res_val_d  = 1'b1;
                grp_cnt_d  = '0;
            end else begin
                acc_re_d  = sum_re;
                acc_im_d  = sum_im;
                grp_cnt_d = grp_cnt_q + LW'(1);
                res_val_d = 1'b0;
            end
        end

        if (res_val_q && res_rdy) res_cnt_d = res_cnt_q + CNT_W'(1);

        if (sw_rst) begin
            s1_val_d   = 1'b0;
            res_val_d  = 1'b0;
            res_data_d = '0;
            acc_re_d   = '0;
            acc_im_d   = '0;
            grp_cnt_d  = '0;
            len_d      = LW'(1);
            mode_d     = MODE_MUL;
            res_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_val_q   <= 1'b0;
            pxx_q      <= '0;
            pyy_q      <= '0;
            pxy_q      <= '0;
            pyx_q      <= '0;
            res_val_q  <= 1'b0;
            res_data_q <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            grp_cnt_q  <= '0;
            len_q      <= LW'(1);
            mode_q     <= MODE_MUL;
            res_cnt_q  <= '0;
        end else begin
            s1_val_q   <= s1_val_d;
            pxx_q      <= pxx_d;
            pyy_q      <= pyy_d;
            pxy_q      <= pxy_d;
            pyx_q      <= pyx_d;
            res_val_q  <= res_val_d;
            res_data_q <= res_data_d;
            acc_re_q   <= acc_re_d;
            acc_im_q   <= acc_im_d;
            grp_cnt_q  <= grp_cnt_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            res_cnt_q  <= res_cnt_d;
        end
    end

    assign op_rdy   = adv;
    assign res_val  = res_val_q;
    assign res_data = res_data_q;
    assign res_cnt  = res_cnt_q;

endmodule

// File: tb/tb_comp_mac_pipe.sv
// Directed bench for comp_mac_pipe (DWIDTH=8, ACC_GUARD=4): single-op latency,
// MUL/CMUL/MAC values, back-pressure, config shadowing and sw reset mid-group.
module tb_comp_mac_pipe;
    localparam int DW = 8;
    localparam int G  = 4;
    localparam int CW = 16;
    localparam int RW = 2*DW + 1 + G;

    logic            clk = 1'b0;
    logic            rst_n, sw_rst;
    logic [1:0]      cfg_mode;
    logic [G:0]      cfg_acc_len;
    logic            op_val, op_rdy, res_val, res_rdy, busy;
    logic [4*DW-1:0] op_data;
    logic [2*RW-1:0] res_data;
    logic [CW-1:0]   res_cnt;

    int n_run  = 0;
    int n_fail = 0;

    logic [4*DW-1:0] s_ops[8];
    logic [2*RW-1:0] s_exp[8];

    comp_mac_pipe #(.DWIDTH(DW), .ACC_GUARD(G), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst),
        .cfg_mode(cfg_mode), .cfg_acc_len(cfg_acc_len),
        .op_val(op_val), .op_rdy(op_rdy), .op_data(op_data),
        .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
        .busy(busy), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*DW-1:0] opd(input int x1, input int x2, input int y1, input int y2);
        return {8'(x1), 8'(x2), 8'(y1), 8'(y2)};
    endfunction

    function automatic logic [2*RW-1:0] mk(input int xr, input int yr);
        return {21'(xr), 21'(yr)};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op(input string tag, input logic [4*DW-1:0] d, input logic [2*RW-1:0] e);
        op_val = 1'b1; op_data = d;
        #1 chk({tag, "_rdy"}, 64'(op_rdy), 64'd1);
        @(posedge clk); #1;
        op_val = 1'b0;
        chk({tag, "_val_e1"}, 64'(res_val), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_val_e2"}, 64'(res_val), 64'd1);
        chk({tag, "_data"}, 64'(res_data), 64'(e));
        @(posedge clk); #1;
    endtask

    task automatic mac_group(input string tag, input int n, input logic [4*DW-1:0] d,
                             input logic [2*RW-1:0] e);
        int early = 0;
        for (int i = 0; i < n; i++) begin
            op_val = 1'b1; op_data = d;
            @(posedge clk); #1;
            if (res_val) early++;
        end
        op_val = 1'b0;
        chk({tag, "_no_early"}, 64'(early), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_val"}, 64'(res_val), 64'd1);
        chk({tag, "_data"}, 64'(res_data), 64'(e));
        @(posedge clk); #1;
        chk({tag, "_done"}, 64'(busy), 64'd0);
    endtask

    // Streams n ops from s_ops, checking results against s_exp in order.
    // res_rdy is low in cycles st_lo..st_hi; cfg_mode flips to CMUL at sw_cyc.
    task automatic run_stream(input string tag, input int n, input int st_lo,
                              input int st_hi, input int sw_cyc);
        int sent = 0, got = 0, cyc = 0;
        bit have_hold = 0, stall;
        logic [2*RW-1:0] hold = '0;
        while ((sent < n || got < n) && cyc < 60) begin
            if (cyc == sw_cyc) cfg_mode = 2'd1;
            stall   = (cyc >= st_lo && cyc <= st_hi);
            res_rdy = !stall;
            op_val  = (sent < n);
            op_data = s_ops[(sent < n) ? sent : 0];
            #1;
            if (stall && res_val) begin
                chk({tag, "_oprdy_low"}, 64'(op_rdy), 64'd0);
                if (have_hold) chk({tag, "_stable"}, 64'(res_data), 64'(hold));
                hold = res_data; have_hold = 1;
            end else begin
                have_hold = 0;
            end
            if (op_val && op_rdy) sent++;
            if (res_val && res_rdy) begin
                chk($sformatf("%s_res%0d", tag, got), 64'(res_data), 64'(s_exp[got]));
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        op_val = 1'b0; res_rdy = 1'b1;
        chk({tag, "_count"}, 64'(got), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sw_rst = 1'b0; cfg_mode = 2'd0; cfg_acc_len = '0;
        op_val = 1'b0; op_data = '0; res_rdy = 1'b1;
        #3;
        chk("rst_res_val", 64'(res_val), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(res_cnt), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_op_rdy", 64'(op_rdy), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // MUL and CMUL of a=3+j4, b=5-j2
        cfg_mode = 2'd0; cfg_acc_len = 5'd1; idle(2);
        do_op("mul", opd(3, 5, 4, -2), mk(23, 14));
        chk("mul_cnt", 64'(res_cnt), 64'd1);
        cfg_mode = 2'd1; idle(2);
        do_op("cmul", opd(3, 5, 4, -2), mk(7, 26));
        cfg_mode = 2'd3; idle(2);
        do_op("rsv", opd(3, 5, 4, -2), mk(23, 14));

        // MAC of (-128-j128)^2 = 0 + j32768 per term
        cfg_mode = 2'd2; cfg_acc_len = 5'd4; idle(2);
        mac_group("mac4", 4, opd(-128, -128, -128, -128), mk(0, 131072));
        cfg_acc_len = 5'd16; idle(2);
        mac_group("mac16", 16, opd(-128, -128, -128, -128), mk(0, 524288));
        cfg_acc_len = 5'd0; idle(2);
        do_op("mac_len0", opd(-128, -128, -128, -128), mk(0, 32768));

        // Back-pressure on a MUL stream, counter restarted by hw reset
        cfg_mode = 2'd0; cfg_acc_len = 5'd1;
        rst_n = 1'b0; #1 rst_n = 1'b1;
        idle(2);
        s_ops[0] = opd(3, 5, 4, -2);          s_exp[0] = mk(23, 14);
        s_ops[1] = opd(1, 1, 0, 0);           s_exp[1] = mk(1, 0);
        s_ops[2] = opd(0, 0, 1, 1);           s_exp[2] = mk(-1, 0);
        s_ops[3] = opd(2, 4, 3, 5);           s_exp[3] = mk(-7, 22);
        s_ops[4] = opd(-128, -128, 0, 0);     s_exp[4] = mk(16384, 0);
        s_ops[5] = opd(127, 127, 127, -128);  s_exp[5] = mk(32385, -127);
        run_stream("bp", 6, 3, 7, -1);
        idle(1);
        chk("bp_cnt", 64'(res_cnt), 64'd6);

        // Mode change while busy: queued ops stay MUL
        for (int i = 0; i < 3; i++) begin
            s_ops[i] = opd(3, 5, 4, -2); s_exp[i] = mk(23, 14);
        end
        run_stream("cfgbusy", 3, 1, 3, 2);
        idle(2);
        do_op("cfg_after", opd(3, 5, 4, -2), mk(7, 26));

        // sw reset in the middle of a MAC group
        cfg_mode = 2'd2; cfg_acc_len = 5'd4; idle(2);
        op_data = opd(-128, -128, -128, -128);
        for (int i = 0; i < 2; i++) begin
            op_val = 1'b1;
            @(posedge clk); #1;
        end
        op_val = 1'b0;
        chk("swr_pre_busy", 64'(busy), 64'd1);
        sw_rst = 1'b1;
        @(posedge clk); #1;
        sw_rst = 1'b0;
        chk("swr_res_val", 64'(res_val), 64'd0);
        chk("swr_busy", 64'(busy), 64'd0);
        chk("swr_cnt", 64'(res_cnt), 64'd0);
        mac_group("swr_mac", 4, opd(1, 1, 0, 0), mk(4, 0));
        chk("swr_cnt_after", 64'(res_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
